perm_index_sorter: RTL
======================

# perm_index_sorter

Sequential argsort stage that sits directly upstream of the nine-lane byte reorder stage. It accepts a vector of nine keys plus nine data bytes through a valid/ready handshake. It sorts the keys with a 9-phase odd-even transposition network and presents the resulting permutation as `index0..index8`, with the captured bytes held on `data_out0..data_out8`. Those outputs wire straight to the reorder stage's `data_inN`/`indexN` inputs.

## Interface
- `KEY_W`, 8: key width in bits.
- `DATA_W`, 8: data byte width. The downstream reorder stage requires 8.
- `DESCENDING`, 0: 0 sorts ascending; 1 sorts descending.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  block can accept a vector.
- `key0..key8`  in  KEY_W each  sort keys.
- `data_in0..data_in8`  in  DATA_W each  payload bytes, captured alongside the keys.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `index0..index8`  out  4 each  `indexK` is the original lane number of the K-th element in sorted order.
- `data_out0..data_out8`  out  DATA_W each  captured payload, unchanged lane order.

## Operation
- FSM states: IDLE, SORT, DONE.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&&`in_ready`, register:
    - `keyK` into `kreg[K]`;
    - `data_inK` into `data_outK`;
    - `idx[K]`=K.
  - Then clear `phase`=0 and go to SORT.
- **SORT**
  - `in_ready`=0, `out_valid`=0. `in_valid` is ignored.
  - Each cycle executes one phase.
    - Even phase compares pairs (0,1), (2,3), (4,5), (6,7).
    - Odd phase compares pairs (1,2), (3,4), (5,6), (7,8).
  - Compare-swap rule:
    - Swap `(kreg, idx)` of pair (i, i+1) iff `kreg[i] > kreg[i+1]`, or `<` when DESCENDING=1.
    - Comparison is unsigned.
    - Equal keys never swap, so the sort is stable: ties keep ascending original lane order.
  - `phase` is a 4-bit counter, 0..8. On the edge where `phase`==8, go to DONE.
- **DONE**
  - `out_valid`=1, `in_ready`=0.
  - `index*` and `data_out*` are held stable.
  - On `out_ready`, go to IDLE.
- `index*` always drive the `idx` registers. They are a permutation of 0..8 at all times, so the downstream never sees an out-of-range index.
- `in_ready` and `out_valid` are decoded from state only, with no combinational input-to-output paths.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `phase`=0;
  - `in_ready`=1, `out_valid`=0;
  - `indexK`=K (identity), `data_outK`=0, `kreg`=0.
- Latency: call the accepting edge E0. The nine SORT phases occur at edges E1..E9, and `out_valid` is high after E9.
- Minimum initiation interval is 11 cycles: accept, 9 sort cycles, 1 DONE cycle with `out_ready` already high. IDLE then lasts at least one cycle before the next accept.
- `out_ready` held low: DONE is held indefinitely, outputs are frozen, and `in_ready` stays 0.
- `out_ready` high while in IDLE or SORT: no effect.
- `rst_n` asserted mid-SORT or in DONE: the vector is aborted immediately, all registers take their reset values, and no `out_valid` pulse follows.
- Already-sorted input, or all-equal keys: the result is identity 0..8.

## Test plan
- Reset, then idle: `index`=0,1,..,8, `data_out`=0, `in_ready`=1, `out_valid`=0.
- Keys 9,8,7,6,5,4,3,2,1 with `data_inK`=0xA0+K, `out_ready`=1:
  - `out_valid` rises 9 cycles after the accept edge;
  - `index`=8,7,6,5,4,3,2,1,0;
  - `data_outK`=0xA0+K.
- Keys 0x10,0x05,0x10,0x05,0x00,0xFF,0x05,0x10,0x00: `index`=4,8,1,3,6,0,2,7,5, exercising stability on ties.
- Same keys with DESCENDING=1: `index`=5,0,2,7,1,3,6,4,8.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles: outputs are stable and `in_ready`=0, with `in_valid` pulses ignored.
  - Release: IDLE follows and the next vector is accepted.
- Assert `rst_n`=0 at phase 4: outputs return to reset values at once and no `out_valid` is produced.
- Reference-model check: 1000 random vectors against a stable argsort, chaining the outputs into the reorder stage, whose `data_out` must match the key-sorted payload.

Source files
------------

// File: rtl/perm_index_sorter.sv
// Sequential argsort: captures nine keys plus payload bytes, runs a 9-phase
// odd-even transposition network and presents the stable sorted permutation.
module perm_index_sorter #(
  parameter int KEY_W      = 8,
  parameter int DATA_W     = 8,
  parameter int DESCENDING = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  key0,
  input  logic [KEY_W-1:0]  key1,
  input  logic [KEY_W-1:0]  key2,
  input  logic [KEY_W-1:0]  key3,
  input  logic [KEY_W-1:0]  key4,
  input  logic [KEY_W-1:0]  key5,
  input  logic [KEY_W-1:0]  key6,
  input  logic [KEY_W-1:0]  key7,
  input  logic [KEY_W-1:0]  key8,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic [DATA_W-1:0] data_in5,
  input  logic [DATA_W-1:0] data_in6,
  input  logic [DATA_W-1:0] data_in7,
  input  logic [DATA_W-1:0] data_in8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        index0,
  output logic [3:0]        index1,
  output logic [3:0]        index2,
  output logic [3:0]        index3,
  output logic [3:0]        index4,
  output logic [3:0]        index5,
  output logic [3:0]        index6,
  output logic [3:0]        index7,
  output logic [3:0]        index8,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [DATA_W-1:0] data_out4,
  output logic [DATA_W-1:0] data_out5,
  output logic [DATA_W-1:0] data_out6,
  output logic [DATA_W-1:0] data_out7,
  output logic [DATA_W-1:0] data_out8
);

  localparam int N = 9;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_phase;
  logic [KEY_W-1:0]  r_kreg [N];
  logic [3:0]        r_idx  [N];
  logic [DATA_W-1:0] r_data [N];

  logic [KEY_W-1:0]  w_key_in  [N];
  logic [DATA_W-1:0] w_din     [N];
  logic [KEY_W-1:0]  w_kreg_nxt[N];
  logic [3:0]        w_idx_nxt [N];
  logic              w_accept;

  assign w_key_in[0] = key0;
  assign w_key_in[1] = key1;
  assign w_key_in[2] = key2;
  assign w_key_in[3] = key3;
  assign w_key_in[4] = key4;
  assign w_key_in[5] = key5;
  assign w_key_in[6] = key6;
  assign w_key_in[7] = key7;
  assign w_key_in[8] = key8;

  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;
  assign w_din[4] = data_in4;
  assign w_din[5] = data_in5;
  assign w_din[6] = data_in6;
  assign w_din[7] = data_in7;
  assign w_din[8] = data_in8;

  assign index0 = r_idx[0];
  assign index1 = r_idx[1];
  assign index2 = r_idx[2];
  assign index3 = r_idx[3];
  assign index4 = r_idx[4];
  assign index5 = r_idx[5];
  assign index6 = r_idx[6];
  assign index7 = r_idx[7];
  assign index8 = r_idx[8];

  assign data_out0 = r_data[0];
  assign data_out1 = r_data[1];
  assign data_out2 = r_data[2];
  assign data_out3 = r_data[3];
  assign data_out4 = r_data[4];
  assign data_out5 = r_data[5];
  assign data_out6 = r_data[6];
  assign data_out7 = r_data[7];
  assign data_out8 = r_data[8];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && (r_state == IDLE);

  // Strict compare so equal keys never move: this is what keeps the sort stable.
  function automatic logic f_swap(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    if (DESCENDING != 0) return (a < b);
    else                 return (a > b);
  endfunction

  // Pairs within one phase are disjoint, so all of them read the registered values.
  always_comb begin
    w_kreg_nxt = r_kreg;
    w_idx_nxt  = r_idx;
    for (int i = 0; i < N-1; i++) begin
      if ((1'(i) == r_phase[0]) && f_swap(r_kreg[i], r_kreg[i+1])) begin
        w_kreg_nxt[i]   = r_kreg[i+1];
        w_kreg_nxt[i+1] = r_kreg[i];
        w_idx_nxt[i]    = r_idx[i+1];
        w_idx_nxt[i+1]  = r_idx[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)          w_state_nxt = SORT;
      SORT:    if (r_phase == 4'd8)   w_state_nxt = DONE;
      DONE:    if (out_ready)         w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_phase <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_phase <= 4'd0;
      else if (r_state == SORT)
        r_phase <= (r_phase == 4'd8) ? 4'd0 : r_phase + 4'd1;
    end
  end

  // Index registers come out of reset as the identity so downstream always sees a permutation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        r_kreg[k] <= '0;
        r_idx[k]  <= 4'(k);
        r_data[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < N; k++) begin
        r_kreg[k] <= w_key_in[k];
        r_idx[k]  <= 4'(k);
        r_data[k] <= w_din[k];
      end
    end else if (r_state == SORT) begin
      r_kreg <= w_kreg_nxt;
      r_idx  <= w_idx_nxt;
    end
  end

endmodule
